// File: rtl/alu_pkg.sv
// Shared types for the ALU operation sequencer: opcode encoding, legality check,
// default operand width and the sequencer FSM state type.
package alu_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_MUL = 3'd2,
        ALU_EQ  = 3'd3,
        ALU_GT  = 3'd4
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } seq_state_e;

    // Opcodes 101..111 are reserved and never reach the ALU.
    function automatic logic is_legal_op(input logic [2:0] op);
        return (op <= 3'(ALU_GT));
    endfunction

endpackage

// File: rtl/alu_ref_model.sv
// Combinational reference ALU: opcode + signed operands -> expected result.
// Illegal opcodes produce zero.
module alu_ref_model
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [2:0]            opcode,
    input  logic [DATA_WIDTH-1:0] operand1,
    input  logic [DATA_WIDTH-1:0] operand2,
    output logic [DATA_WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        case (opcode)
            ALU_ADD: result = operand1 + operand2;
            ALU_SUB: result = operand1 - operand2;
            // Low half of a two's complement product is sign-agnostic.
            ALU_MUL: result = operand1 * operand2;
            ALU_EQ:  result = {{(DATA_WIDTH-1){1'b0}}, (operand1 == operand2)};
            ALU_GT:  result = {{(DATA_WIDTH-1){1'b0}}, ($signed(operand1) > $signed(operand2))};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Valid/ready front end that issues one operation to a fixed-latency ALU and returns its result.
// Define ALU_OP_SEQUENCER_SELFCHECK_EN to add a reference-model result checker.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int ALU_LATENCY = 2,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock_in,
    input  logic                   reset_n_in,
    input  logic                   cmd_valid_in,
    output logic                   cmd_ready_out,
    input  logic [2:0]             cmd_opcode_in,
    input  logic [DATA_WIDTH-1:0]  cmd_operand1_in,
    input  logic [DATA_WIDTH-1:0]  cmd_operand2_in,
    output logic                   alu_enable_out,
    output logic [2:0]             alu_opcode_out,
    output logic [DATA_WIDTH-1:0]  alu_input1_out,
    output logic [DATA_WIDTH-1:0]  alu_input2_out,
    input  logic [DATA_WIDTH-1:0]  alu_output_in,
    output logic                   rsp_valid_out,
    input  logic                   rsp_ready_in,
    output logic [DATA_WIDTH-1:0]  rsp_result_out,
    output logic [2:0]             rsp_opcode_out,
    output logic                   rsp_illegal_out,
    output logic                   busy_out,
    output logic [COUNT_WIDTH-1:0] op_count_out
`ifdef ALU_OP_SEQUENCER_SELFCHECK_EN
    ,
    output logic                   mismatch_out,
    output logic [7:0]             mismatch_count_out
`endif
);

    localparam int CNT_W = $clog2(ALU_LATENCY + 1);

    seq_state_e       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             accept;
    logic             capture;

    assign accept  = cmd_valid_in & cmd_ready_out;
    // Counter is loaded with ALU_LATENCY at accept, so reaching 1 marks the final wait edge.
    assign capture = (state_reg == ST_WAIT) && (cnt_reg == CNT_W'(1));

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            cmd_ready_out   <= 1'b1;
            alu_enable_out  <= 1'b0;
            alu_opcode_out  <= '0;
            alu_input1_out  <= '0;
            alu_input2_out  <= '0;
            rsp_valid_out   <= 1'b0;
            rsp_result_out  <= '0;
            rsp_opcode_out  <= '0;
            rsp_illegal_out <= 1'b0;
            busy_out        <= 1'b0;
            op_count_out    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        alu_opcode_out <= cmd_opcode_in;
                        alu_input1_out <= cmd_operand1_in;
                        alu_input2_out <= cmd_operand2_in;
                        rsp_opcode_out <= cmd_opcode_in;
                        rsp_result_out <= '0;
                        cmd_ready_out  <= 1'b0;
                        busy_out       <= 1'b1;
                        if (is_legal_op(cmd_opcode_in)) begin
                            alu_enable_out  <= 1'b1;
                            rsp_illegal_out <= 1'b0;
                            cnt_reg         <= CNT_W'(ALU_LATENCY);
                            state_reg       <= ST_WAIT;
                        end else begin
                            alu_enable_out  <= 1'b0;
                            rsp_illegal_out <= 1'b1;
                            rsp_valid_out   <= 1'b1;
                            state_reg       <= ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    if (capture) begin
                        rsp_result_out <= alu_output_in;
                        rsp_valid_out  <= 1'b1;
                        alu_enable_out <= 1'b0;
                        state_reg      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_in) begin
                        rsp_valid_out <= 1'b0;
                        op_count_out  <= op_count_out + COUNT_WIDTH'(1);
                        cmd_ready_out <= 1'b1;
                        busy_out      <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

`ifdef ALU_OP_SEQUENCER_SELFCHECK_EN
    logic [DATA_WIDTH-1:0] expected_result;

    alu_ref_model #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ref_model (
        .opcode   (alu_opcode_out),
        .operand1 (alu_input1_out),
        .operand2 (alu_input2_out),
        .result   (expected_result)
    );

    // Only legal operations pass through WAIT, so illegal opcodes are never checked.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            mismatch_out       <= 1'b0;
            mismatch_count_out <= '0;
        end else if (capture && (alu_output_in != expected_result)) begin
            mismatch_out <= 1'b1;
            if (mismatch_count_out != 8'hFF) begin
                mismatch_count_out <= mismatch_count_out + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer with a one-stage ALU model behind it.
// Define ALU_OP_SEQUENCER_SELFCHECK_EN to also exercise the mismatch checker.
module tb_alu_op_sequencer;

    localparam int LAT = 2;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_opcode;
    logic [7:0]  cmd_op1;
    logic [7:0]  cmd_op2;
    logic        alu_enable;
    logic [2:0]  alu_opcode;
    logic [7:0]  alu_in1;
    logic [7:0]  alu_in2;
    logic [7:0]  alu_output;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_result;
    logic [2:0]  rsp_opcode;
    logic        rsp_illegal;
    logic        busy;
    logic [15:0] op_count;
    logic        force_zero;
`ifdef ALU_OP_SEQUENCER_SELFCHECK_EN
    logic        mismatch;
    logic [7:0]  mismatch_count;
`endif

    int errors = 0;
    int checks = 0;

    alu_op_sequencer #(
        .DATA_WIDTH(8),
        .ALU_LATENCY(LAT),
        .COUNT_WIDTH(16)
    ) dut (
        .clock_in        (clk),
        .reset_n_in      (rst_n),
        .cmd_valid_in    (cmd_valid),
        .cmd_ready_out   (cmd_ready),
        .cmd_opcode_in   (cmd_opcode),
        .cmd_operand1_in (cmd_op1),
        .cmd_operand2_in (cmd_op2),
        .alu_enable_out  (alu_enable),
        .alu_opcode_out  (alu_opcode),
        .alu_input1_out  (alu_in1),
        .alu_input2_out  (alu_in2),
        .alu_output_in   (alu_output),
        .rsp_valid_out   (rsp_valid),
        .rsp_ready_in    (rsp_ready),
        .rsp_result_out  (rsp_result),
        .rsp_opcode_out  (rsp_opcode),
        .rsp_illegal_out (rsp_illegal),
        .busy_out        (busy),
        .op_count_out    (op_count)
`ifdef ALU_OP_SEQUENCER_SELFCHECK_EN
        ,
        .mismatch_out       (mismatch),
        .mismatch_count_out (mismatch_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a * b;
            3'd3:    return {7'd0, a == b};
            3'd4:    return {7'd0, $signed(a) > $signed(b)};
            default: return 8'd0;
        endcase
    endfunction

    // One register stage: output valid one edge after operands, sampled by the DUT on the next.
    always @(posedge clk) begin
        alu_output <= force_zero ? 8'd0 : alu_fn(alu_opcode, alu_in1, alu_in2);
    end

    task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_res, input logic [15:0] exp_count);
        int lat;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_opcode = op; cmd_op1 = a; cmd_op2 = b;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== LAT + 1) begin
            errors++; $display("FAIL latency op=%0d: got %0d negedges, required %0d", op, lat, LAT + 1);
        end
        checks++;
        if (rsp_result !== exp_res) begin
            errors++; $display("FAIL result op=%0d: got %h, required %h", op, rsp_result, exp_res);
        end
        checks++;
        if (rsp_opcode !== op || rsp_illegal !== 1'b0) begin
            errors++; $display("FAIL rsp_opcode/illegal: got %0d/%b, required %0d/0", rsp_opcode, rsp_illegal, op);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || op_count !== exp_count) begin
            errors++;
            $display("FAIL handshake: valid=%b ready=%b busy=%b count=%0d, required 0 1 0 %0d",
                     rsp_valid, cmd_ready, busy, op_count, exp_count);
        end
        $display("op=%0d a=%h b=%h result=%h count=%0d", op, a, b, rsp_result, op_count);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || alu_enable !== 1'b0 || op_count !== 16'd0 ||
            rsp_result !== 8'd0 || alu_in1 !== 8'd0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL reset_state: valid=%b busy=%b en=%b count=%0d ready=%b, required 0 0 0 0 1",
                               rsp_valid, busy, alu_enable, op_count, cmd_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle: ready=%b busy=%b, required 1 0", cmd_ready, busy);
        end
        $display("reset done");
    endtask

    task automatic test_add();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_opcode = 3'd0; cmd_op1 = 8'd100; cmd_op2 = 8'd27;
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if (alu_enable !== 1'b1 || alu_in1 !== 8'd100 || alu_in2 !== 8'd27 || cmd_ready !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL add_issue: en=%b in1=%0d in2=%0d ready=%b busy=%b, required 1 100 27 0 1",
                               alu_enable, alu_in1, alu_in2, cmd_ready, busy);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || alu_enable !== 1'b1) begin
            errors++; $display("FAIL add_early: valid=%b en=%b, required 0 1", rsp_valid, alu_enable);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 8'd127 || alu_enable !== 1'b0) begin
            errors++; $display("FAIL add_result: valid=%b result=%0d en=%b, required 1 127 0", rsp_valid, rsp_result, alu_enable);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (op_count !== 16'd1 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL add_handshake: count=%0d valid=%b ready=%b, required 1 0 1", op_count, rsp_valid, cmd_ready);
        end
        $display("op=0 a=64 b=1b result=%h count=%0d", rsp_result, op_count);
    endtask

    task automatic test_arith();
        run_op(3'd1, 8'h80, 8'h01, 8'h7F, 16'd2);
        run_op(3'd2, 8'h80, 8'hFF, 8'h80, 16'd3);
        run_op(3'd4, 8'hFF, 8'h00, 8'h00, 16'd4);
        run_op(3'd3, 8'h05, 8'h05, 8'h01, 16'd5);
        run_op(3'd4, 8'h03, 8'hFD, 8'h01, 16'd6);
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_opcode = 3'd0; cmd_op1 = 8'd3; cmd_op2 = 8'd4;
        @(negedge clk);
        cmd_opcode = 3'd1; cmd_op1 = 8'd50; cmd_op2 = 8'd9;
        repeat (LAT) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_result !== 8'd7 || rsp_opcode !== 3'd0 || cmd_ready !== 1'b0 ||
                alu_opcode !== 3'd0 || alu_in1 !== 8'd3) begin
                errors++; $display("FAIL backpressure cycle %0d: valid=%b result=%0d op=%0d ready=%b alu_op=%0d, required 1 7 0 0 0",
                                   i, rsp_valid, rsp_result, rsp_opcode, cmd_ready, alu_opcode);
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || op_count !== 16'd7 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL backpressure_release: valid=%b count=%0d ready=%b, required 0 7 1", rsp_valid, op_count, cmd_ready);
        end
        $display("op=0 a=03 b=04 result=07 count=%0d (after 10 stalled cycles)", op_count);
    endtask

    task automatic test_illegal();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_opcode = 3'd6; cmd_op1 = 8'd9; cmd_op2 = 8'd9;
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_illegal !== 1'b1 || rsp_result !== 8'd0 || rsp_opcode !== 3'd6 || alu_enable !== 1'b0) begin
            errors++; $display("FAIL illegal_rsp: valid=%b ill=%b result=%0d op=%0d en=%b, required 1 1 0 6 0",
                               rsp_valid, rsp_illegal, rsp_result, rsp_opcode, alu_enable);
        end
        @(negedge clk);
        checks++;
        if (alu_enable !== 1'b0 || rsp_valid !== 1'b1) begin
            errors++; $display("FAIL illegal_hold: en=%b valid=%b, required 0 1", alu_enable, rsp_valid);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (op_count !== 16'd8 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL illegal_count: count=%0d valid=%b, required 8 0", op_count, rsp_valid);
        end
        $display("op=6 a=09 b=09 illegal result=00 count=%0d", op_count);
    endtask

    task automatic test_reset_mid_wait();
        int seen;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_opcode = 3'd0; cmd_op1 = 8'd1; cmd_op2 = 8'd2;
        @(negedge clk);
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || alu_enable !== 1'b0 || alu_in1 !== 8'd0 || alu_opcode !== 3'd0 ||
            busy !== 1'b0 || op_count !== 16'd0 || rsp_result !== 8'd0) begin
            errors++; $display("FAIL reset_mid_wait: valid=%b en=%b in1=%0d busy=%b count=%0d, required all 0",
                               rsp_valid, alu_enable, alu_in1, busy, op_count);
        end
        rst_n = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL dropped_op: got %0d response cycles, required 0", seen);
        end
        $display("reset mid-wait: in-flight op dropped");
        run_op(3'd0, 8'd10, 8'd20, 8'd30, 16'd1);
    endtask

`ifdef ALU_OP_SEQUENCER_SELFCHECK_EN
    task automatic test_selfcheck();
        force_zero = 1'b1;
        run_op(3'd0, 8'd1, 8'd1, 8'd0, 16'd2);
        force_zero = 1'b0;
        checks++;
        if (mismatch !== 1'b1 || mismatch_count !== 8'd1) begin
            errors++; $display("FAIL selfcheck_detect: flag=%b count=%0d, required 1 1", mismatch, mismatch_count);
        end
        run_op(3'd0, 8'd2, 8'd2, 8'd4, 16'd3);
        checks++;
        if (mismatch !== 1'b1 || mismatch_count !== 8'd1) begin
            errors++; $display("FAIL selfcheck_clean: flag=%b count=%0d, required 1 1", mismatch, mismatch_count);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_opcode = 3'd0; cmd_op1 = 8'd0; cmd_op2 = 8'd0;
        rsp_ready = 1'b0; force_zero = 1'b0;
        test_reset();
        test_add();
        test_arith();
        test_backpressure();
        test_illegal();
        test_reset_mid_wait();
`ifdef ALU_OP_SEQUENCER_SELFCHECK_EN
        test_selfcheck();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
